// File: rtl/dspba_stall_ctrl.sv
// Elastic valid/ready wrapper around a fixed-latency, enable-stalled DSPBA core.
// Define DSPBA_SKID_EN to add a 2-entry output skid FIFO that breaks the ready_out -> ready_in path.
module dspba_stall_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DATAW   = 32,
  parameter int unsigned TAGW    = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [TAGW-1:0]  tag_in,
  output logic             core_ena,
  input  logic [DATAW-1:0] core_result,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out,
  output logic [TAGW-1:0]  tag_out,
  output logic             idle
);

  logic [LATENCY-1:0] valid_sr_q, valid_sr_d;
  logic [TAGW-1:0]    tag_sr_q [LATENCY];
  logic [TAGW-1:0]    tag_sr_d [LATENCY];
  logic               fire_in;

  assign ready_in = core_ena;
  assign fire_in  = valid_in & ready_in;

  // Valid/tag shadow of the core: every stage moves together, bubbles included.
  always_comb begin
    valid_sr_d = valid_sr_q;
    tag_sr_d   = tag_sr_q;
    if (core_ena) begin
      valid_sr_d[0] = fire_in;
      tag_sr_d[0]   = tag_in;
      for (int i = 1; i < int'(LATENCY); i++) begin
        valid_sr_d[i] = valid_sr_q[i-1];
        tag_sr_d[i]   = tag_sr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      valid_sr_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) tag_sr_q[i] <= '0;
    end else begin
      valid_sr_q <= valid_sr_d;
      tag_sr_q   <= tag_sr_d;
    end
  end

`ifdef DSPBA_SKID_EN
  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [TAGW-1:0]  tag;
  } skid_ent_t;

  skid_ent_t  skid_q [2];
  skid_ent_t  skid_d [2];
  skid_ent_t  new_ent;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign core_ena  = (count_q != 2'd2);
  assign push      = core_ena & valid_sr_q[LATENCY-1];
  assign pop       = valid_out & ready_out;
  assign valid_out = (count_q != 2'd0);
  assign data_out  = valid_out ? skid_q[0].data : '0;
  assign tag_out   = valid_out ? skid_q[0].tag  : '0;
  assign idle      = ~|valid_sr_q & (count_q == 2'd0);
  assign new_ent   = '{data: core_result, tag: tag_sr_q[LATENCY-1]};

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    skid_d  = skid_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        skid_d[count_q[0]] = new_ent;
        count_d            = count_q + 2'd1;
      end
      2'b01: begin
        skid_d[0] = skid_q[1];
        count_d   = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          skid_d[0] = new_ent;
        end else begin
          skid_d[0] = skid_q[1];
          skid_d[1] = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      count_q   <= 2'd0;
    end else begin
      skid_q  <= skid_d;
      count_q <= count_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (aclr)
    !(push && (count_q == 2'd2)));
  a_count_range: assert property (@(posedge clk) disable iff (aclr)
    (count_q <= 2'd2));
`else
  assign core_ena  = ~(valid_sr_q[LATENCY-1] & ~ready_out);
  assign valid_out = valid_sr_q[LATENCY-1];
  assign data_out  = core_result;
  assign tag_out   = tag_sr_q[LATENCY-1];
  assign idle      = ~|valid_sr_q;
`endif

endmodule

// File: tb/tb_dspba_stall_ctrl.sv
// Scoreboard bench for dspba_stall_ctrl: LATENCY=4 directed scenarios plus a LATENCY=1 random run.
module tb_dspba_stall_ctrl;

`ifdef DSPBA_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int LAT4 = 4 + SKID;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        aclr;
  logic        vin, rdy_in, cen, vout, rout, idle_o;
  logic [7:0]  tin, tout;
  logic [31:0] core_res, dout;
  logic        vin1, rdy_in1, cen1, vout1, rout1, idle1;
  logic [7:0]  tin1, tout1;
  logic [31:0] core_res1, dout1;

  int errors = 0;
  int checks = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  dspba_stall_ctrl #(.LATENCY(4), .DATAW(32), .TAGW(8)) dut (
    .clk(clk), .aclr(aclr), .valid_in(vin), .ready_in(rdy_in), .tag_in(tin),
    .core_ena(cen), .core_result(core_res), .valid_out(vout), .ready_out(rout),
    .data_out(dout), .tag_out(tout), .idle(idle_o));

  dspba_stall_ctrl #(.LATENCY(1), .DATAW(32), .TAGW(8)) dut1 (
    .clk(clk), .aclr(aclr), .valid_in(vin1), .ready_in(rdy_in1), .tag_in(tin1),
    .core_ena(cen1), .core_result(core_res1), .valid_out(vout1), .ready_out(rout1),
    .data_out(dout1), .tag_out(tout1), .idle(idle1));

  function automatic logic [31:0] exp_data(input logic [7:0] t);
    return {t ^ 8'hA5, t, ~t, t + 8'h3C};
  endfunction

  // Behavioural cores: ena-gated delay chains fed with data derived from the request tag.
  logic [31:0] cr4 [4];
  logic [31:0] cr1;
  always @(posedge clk) begin
    if (cen) begin
      cr4[0] <= exp_data(tin);
      for (int i = 1; i < 4; i++) cr4[i] <= cr4[i-1];
    end
    if (cen1) cr1 <= exp_data(tin1);
  end
  assign core_res  = cr4[3];
  assign core_res1 = cr1;

  // Scoreboards: push on accept, pop and compare on each downstream transfer.
  always @(negedge clk) begin
    exp_t e;
    if (aclr) begin
      q4.delete();
      q1.delete();
    end else begin
      if (vout && rout) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected: got tag=%02h data=%08h, required no response", tout, dout);
        end else begin
          e = q4.pop_front();
          if (tout !== e.tag || dout !== e.data) begin
            errors++;
            $display("FAIL sb4_order: got tag=%02h data=%08h, required tag=%02h data=%08h",
                     tout, dout, e.tag, e.data);
          end
        end
      end
      if (vin && rdy_in) q4.push_back('{tag: tin, data: exp_data(tin)});
      if (vout1 && rout1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb1_unexpected: got tag=%02h data=%08h, required no response", tout1, dout1);
        end else begin
          e = q1.pop_front();
          if (tout1 !== e.tag || dout1 !== e.data) begin
            errors++;
            $display("FAIL sb1_order: got tag=%02h data=%08h, required tag=%02h data=%08h",
                     tout1, dout1, e.tag, e.data);
          end
        end
      end
      if (vin1 && rdy_in1) q1.push_back('{tag: tin1, data: exp_data(tin1)});
    end
  end

  task automatic test_reset();
    aclr = 1'b1; vin = 1'b0; tin = 8'h00; rout = 1'b1;
    vin1 = 1'b0; tin1 = 8'h00; rout1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (vout !== 1'b0)   begin errors++; $display("FAIL reset_valid_out: got %b, required 0", vout); end
    if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, required 1", idle_o); end
    if (tout !== 8'h00)  begin errors++; $display("FAIL reset_tag_out: got %02h, required 00", tout); end
    if (cen !== 1'b1)    begin errors++; $display("FAIL reset_core_ena: got %b, required 1", cen); end
    if (vout1 !== 1'b0 || idle1 !== 1'b1) begin
      errors++; $display("FAIL reset_l1: got valid_out=%b idle=%b, required 0/1", vout1, idle1);
    end
`ifdef DSPBA_SKID_EN
    checks++;
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %08h, required 0", dout); end
`endif
    @(posedge clk); #1;
    aclr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int t = 0; t < 25; t++) begin
      @(posedge clk); #1;
      vin = (t < 8); tin = 8'(t + 1); rout = 1'b1;
      @(negedge clk);
      if (t < 8) begin
        checks++;
        if (rdy_in !== 1'b1) begin errors++; $display("FAIL b2b_ready_in: t=%0d got %b, required 1", t, rdy_in); end
      end
      if (vout === 1'b1) begin
        checks++;
        if (t !== LAT4 + n || tout !== 8'(n + 1)) begin
          errors++;
          $display("FAIL b2b_timing: got tag=%02h at cycle %0d, required tag=%02h at cycle %0d",
                   tout, t, 8'(n + 1), LAT4 + n);
        end
        n++;
      end
    end
    checks += 2;
    if (n !== 8) begin errors++; $display("FAIL b2b_count: got %0d responses, required 8", n); end
    if (idle_o !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b, required 1", idle_o); end
  endtask

  task automatic test_stall();
    int k;
    int fires = 0;
    @(posedge clk); #1;
    rout = 1'b0; vin = 1'b1; tin = 8'h5A;
    @(posedge clk); #1;
    vin = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vout === 1'b1) break;
    end
    checks++;
    if (k == 20) begin errors++; $display("FAIL stall_timeout: valid_out never rose, required 1"); end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (vout !== 1'b1 || tout !== 8'h5A || dout !== exp_data(8'h5A) || cen !== 1'(SKID)) begin
        errors++;
        $display("FAIL stall_hold: j=%0d got v=%b tag=%02h data=%08h ena=%b, required 1/5a/%08h/%0d",
                 j, vout, tout, dout, cen, exp_data(8'h5A), SKID);
      end
    end
    @(posedge clk); #1;
    rout = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (vout && rout) fires++;
    end
    checks += 2;
    if (fires !== 1) begin errors++; $display("FAIL stall_release: got %0d transfers, required 1", fires); end
    if (idle_o !== 1'b1) begin errors++; $display("FAIL stall_idle: got %b, required 1", idle_o); end
  endtask

  task automatic test_toggle();
    int k;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      vin = 1'b1; tin = 8'(8'h80 + t); rout = (t % 2 == 0);
      @(negedge clk);
`ifdef DSPBA_SKID_EN
      begin
        logic r0;
        #1;
        r0 = rdy_in;
        rout = ~rout;
        #1;
        checks++;
        if (rdy_in !== r0) begin errors++; $display("FAIL toggle_comb_path: got ready_in=%b, required %b", rdy_in, r0); end
        rout = ~rout;
      end
`endif
    end
    @(posedge clk); #1;
    vin = 1'b0; rout = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (idle_o === 1'b1) break;
    end
    checks += 2;
    if (k == 40) begin errors++; $display("FAIL toggle_drain: idle never rose, required 1"); end
    if (q4.size() != 0) begin errors++; $display("FAIL toggle_lost: got %0d outstanding, required 0", q4.size()); end
  endtask

  task automatic test_reset_flight();
    int cnt = 0;
    rout = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vin = 1'b1; tin = 8'(8'h11 + i);
    end
    @(posedge clk); #1;
    vin = 1'b0; aclr = 1'b1;
    #1;
    checks++;
    if (vout !== 1'b0 || idle_o !== 1'b1 || tout !== 8'h00) begin
      errors++; $display("FAIL rst_flight_async: got v=%b idle=%b tag=%02h, required 0/1/00", vout, idle_o, tout);
    end
    @(posedge clk); #1;
    aclr = 1'b0; vin = 1'b1; tin = 8'h77;
    for (int t = 0; t < 15; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        vin = 1'b0;
      end
      @(negedge clk);
      if (vout && rout) begin
        cnt++;
        checks++;
        if (tout !== 8'h77 || t !== LAT4) begin
          errors++; $display("FAIL rst_flight_resp: got tag=%02h at cycle %0d, required 77 at %0d", tout, t, LAT4);
        end
      end
    end
    checks += 2;
    if (cnt !== 1) begin errors++; $display("FAIL rst_flight_count: got %0d responses, required 1", cnt); end
    if (idle_o !== 1'b1 || q4.size() != 0) begin
      errors++; $display("FAIL rst_flight_idle: got idle=%b outstanding=%0d, required 1/0", idle_o, q4.size());
    end
  endtask

  task automatic test_random_l1();
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      vin1 = 1'($urandom_range(0, 1));
      rout1 = ($urandom_range(0, 3) != 0);
      tin1 = 8'($urandom);
    end
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      vin1 = 1'b1; rout1 = 1'b1; tin1 = 8'(t + 8'hC0);
      @(negedge clk);
      if (t >= 5) begin
        checks++;
        if (rdy_in1 !== 1'b1 || vout1 !== 1'b1) begin
          errors++; $display("FAIL l1_throughput: t=%0d got ready_in=%b valid_out=%b, required 1/1", t, rdy_in1, vout1);
        end
      end
    end
    @(posedge clk); #1;
    vin1 = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (idle1 !== 1'b1 || q1.size() != 0) begin
      errors++; $display("FAIL l1_drain: got idle=%b outstanding=%0d, required 1/0", idle1, q1.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_reset_flight();
    test_random_l1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
